// File: rtl/z_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : z_axil_pkg
// Description : Shared definitions for the two-requester AXI4-Lite arbiter:
//               FSM state encoding and AXI response codes.
// Revision    : 1.0 - initial release
// ============================================================================
package z_axil_pkg;

    // Arbiter FSM states; encoding is fixed so it can be observed in debug.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    // AXI response codes carried unmodified through the arbiter.
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

endpackage : z_axil_pkg
`default_nettype wire

// File: rtl/z_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : z_rr_arb2
// Description : Two-input round-robin picker. When both inputs request, the
//               one that was not granted last wins; a sole requester always
//               wins. Purely combinational.
// Ports       : req[1:0] - request per port
//               last     - index of the port granted most recently
//               grant    - one-hot grant (all zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module z_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule : z_rr_arb2
`default_nettype wire

// File: rtl/z_axil_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : z_axil_arbiter
// Description : Shares one AXI4-Lite slave between two requesters
//               (s0 = instruction fetch, s1 = load/store), one transaction
//               at a time. A grant is taken in IDLE and registered; the
//               granted port's channels are then wired straight through to
//               the master port until the response handshake completes.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               s0_* / s1_*         - AXI4-Lite slave ports (requesters)
//               m_*                 - AXI4-Lite master port (shared memory)
// Revision    : 1.0 - initial release
// ============================================================================
module z_axil_arbiter
    import z_axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // requester 0
    input  logic [ADDR_WIDTH-1:0] s0_aw_addr,
    input  logic [2:0]            s0_aw_prot,
    input  logic                  s0_aw_valid,
    output logic                  s0_aw_ready,
    input  logic [DATA_WIDTH-1:0] s0_w_data,
    input  logic [STRB_WIDTH-1:0] s0_w_strb,
    input  logic                  s0_w_valid,
    output logic                  s0_w_ready,
    output logic [1:0]            s0_b_resp,
    output logic                  s0_b_valid,
    input  logic                  s0_b_ready,
    input  logic [ADDR_WIDTH-1:0] s0_ar_addr,
    input  logic [2:0]            s0_ar_prot,
    input  logic                  s0_ar_valid,
    output logic                  s0_ar_ready,
    output logic [DATA_WIDTH-1:0] s0_r_data,
    output logic [1:0]            s0_r_resp,
    output logic                  s0_r_valid,
    input  logic                  s0_r_ready,
    // requester 1
    input  logic [ADDR_WIDTH-1:0] s1_aw_addr,
    input  logic [2:0]            s1_aw_prot,
    input  logic                  s1_aw_valid,
    output logic                  s1_aw_ready,
    input  logic [DATA_WIDTH-1:0] s1_w_data,
    input  logic [STRB_WIDTH-1:0] s1_w_strb,
    input  logic                  s1_w_valid,
    output logic                  s1_w_ready,
    output logic [1:0]            s1_b_resp,
    output logic                  s1_b_valid,
    input  logic                  s1_b_ready,
    input  logic [ADDR_WIDTH-1:0] s1_ar_addr,
    input  logic [2:0]            s1_ar_prot,
    input  logic                  s1_ar_valid,
    output logic                  s1_ar_ready,
    output logic [DATA_WIDTH-1:0] s1_r_data,
    output logic [1:0]            s1_r_resp,
    output logic                  s1_r_valid,
    input  logic                  s1_r_ready,
    // shared memory
    output logic [ADDR_WIDTH-1:0] m_aw_addr,
    output logic [2:0]            m_aw_prot,
    output logic                  m_aw_valid,
    input  logic                  m_aw_ready,
    output logic [DATA_WIDTH-1:0] m_w_data,
    output logic [STRB_WIDTH-1:0] m_w_strb,
    output logic                  m_w_valid,
    input  logic                  m_w_ready,
    input  logic [1:0]            m_b_resp,
    input  logic                  m_b_valid,
    output logic                  m_b_ready,
    output logic [ADDR_WIDTH-1:0] m_ar_addr,
    output logic [2:0]            m_ar_prot,
    output logic                  m_ar_valid,
    input  logic                  m_ar_ready,
    input  logic [DATA_WIDTH-1:0] m_r_data,
    input  logic [1:0]            m_r_resp,
    input  logic                  m_r_valid,
    output logic                  m_r_ready
);

    state_t      r_state;
    logic        r_gnt;      // granted port index, valid in RD/WR
    logic        r_last;     // port granted by the last completed transaction
    logic [1:0]  w_req;
    logic [1:0]  w_grant;
    logic        w_win_aw;
    logic        w_rd;
    logic        w_wr;
    logic        w_done;

    // Selected (granted) requester's request-side signals
    logic [ADDR_WIDTH-1:0] w_aw_addr;
    logic [2:0]            w_aw_prot;
    logic                  w_aw_valid;
    logic [DATA_WIDTH-1:0] w_w_data;
    logic [STRB_WIDTH-1:0] w_w_strb;
    logic                  w_w_valid;
    logic                  w_b_ready;
    logic [ADDR_WIDTH-1:0] w_ar_addr;
    logic [2:0]            w_ar_prot;
    logic                  w_ar_valid;
    logic                  w_r_ready;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_req = {s1_ar_valid | s1_aw_valid, s0_ar_valid | s0_aw_valid};

    z_rr_arb2 u_rr_arb2 (
        .req   (w_req),
        .last  (r_last),
        .grant (w_grant)
    );

    // Writes beat reads inside the winning port.
    assign w_win_aw = w_grant[1] ? s1_aw_valid : s0_aw_valid;

    assign w_rd   = (r_state == RD);
    assign w_wr   = (r_state == WR);
    assign w_done = (w_rd & m_r_valid & m_r_ready) | (w_wr & m_b_valid & m_b_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;     // s0 wins the first tie after reset
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_gnt   <= w_grant[1];
                        r_state <= w_win_aw ? WR : RD;
                    end
                end
                RD, WR: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_last  <= r_gnt;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Requester -> memory path (selected by registered grant)
    // ------------------------------------------------------------------
    always_comb begin
        w_aw_addr  = r_gnt ? s1_aw_addr  : s0_aw_addr;
        w_aw_prot  = r_gnt ? s1_aw_prot  : s0_aw_prot;
        w_aw_valid = r_gnt ? s1_aw_valid : s0_aw_valid;
        w_w_data   = r_gnt ? s1_w_data   : s0_w_data;
        w_w_strb   = r_gnt ? s1_w_strb   : s0_w_strb;
        w_w_valid  = r_gnt ? s1_w_valid  : s0_w_valid;
        w_b_ready  = r_gnt ? s1_b_ready  : s0_b_ready;
        w_ar_addr  = r_gnt ? s1_ar_addr  : s0_ar_addr;
        w_ar_prot  = r_gnt ? s1_ar_prot  : s0_ar_prot;
        w_ar_valid = r_gnt ? s1_ar_valid : s0_ar_valid;
        w_r_ready  = r_gnt ? s1_r_ready  : s0_r_ready;
    end

    // Only the channels of the active operation reach the memory; the rest
    // are held at zero so the memory never sees a stray request.
    always_comb begin
        m_aw_addr  = w_wr ? w_aw_addr : '0;
        m_aw_prot  = w_wr ? w_aw_prot : '0;
        m_aw_valid = w_wr & w_aw_valid;
        m_w_data   = w_wr ? w_w_data  : '0;
        m_w_strb   = w_wr ? w_w_strb  : '0;
        m_w_valid  = w_wr & w_w_valid;
        m_b_ready  = w_wr & w_b_ready;
        m_ar_addr  = w_rd ? w_ar_addr : '0;
        m_ar_prot  = w_rd ? w_ar_prot : '0;
        m_ar_valid = w_rd & w_ar_valid;
        m_r_ready  = w_rd & w_r_ready;
    end

    // ------------------------------------------------------------------
    // Memory -> requester path; the non-granted port sees all zeros
    // ------------------------------------------------------------------
    always_comb begin
        s0_aw_ready = 1'b0;
        s0_w_ready  = 1'b0;
        s0_b_valid  = 1'b0;
        s0_b_resp   = '0;
        s0_ar_ready = 1'b0;
        s0_r_valid  = 1'b0;
        s0_r_data   = '0;
        s0_r_resp   = '0;
        s1_aw_ready = 1'b0;
        s1_w_ready  = 1'b0;
        s1_b_valid  = 1'b0;
        s1_b_resp   = '0;
        s1_ar_ready = 1'b0;
        s1_r_valid  = 1'b0;
        s1_r_data   = '0;
        s1_r_resp   = '0;
        if (w_wr) begin
            if (r_gnt) begin
                s1_aw_ready = m_aw_ready;
                s1_w_ready  = m_w_ready;
                s1_b_valid  = m_b_valid;
                s1_b_resp   = m_b_resp;
            end else begin
                s0_aw_ready = m_aw_ready;
                s0_w_ready  = m_w_ready;
                s0_b_valid  = m_b_valid;
                s0_b_resp   = m_b_resp;
            end
        end
        if (w_rd) begin
            if (r_gnt) begin
                s1_ar_ready = m_ar_ready;
                s1_r_valid  = m_r_valid;
                s1_r_data   = m_r_data;
                s1_r_resp   = m_r_resp;
            end else begin
                s0_ar_ready = m_ar_ready;
                s0_r_valid  = m_r_valid;
                s0_r_data   = m_r_data;
                s0_r_resp   = m_r_resp;
            end
        end
    end

endmodule : z_axil_arbiter
`default_nettype wire

// File: tb/tb_z_axil_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_z_axil_arbiter
// Description : Directed self-checking bench for z_axil_arbiter with a small
//               behavioural AXI4-Lite memory on the master side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_z_axil_arbiter;

    localparam int c_lim = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // requester side, index = port
    logic [1:0][31:0] aw_addr, w_data, ar_addr;
    logic [1:0][2:0]  aw_prot, ar_prot;
    logic [1:0][3:0]  w_strb;
    logic [1:0]       aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic [1:0]       s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid;
    logic [1:0][1:0]  s_b_resp, s_r_resp;
    logic [1:0][31:0] s_r_data;

    // memory side
    logic [31:0] m_aw_addr, m_w_data, m_ar_addr, mr_data;
    logic [2:0]  m_aw_prot, m_ar_prot;
    logic [3:0]  m_w_strb;
    logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_ready;
    logic        m_ar_valid, m_ar_ready, m_r_ready, mr_valid, mb_valid;
    logic [1:0]  mr_resp, mb_resp;

    z_axil_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s0_aw_addr(aw_addr[0]), .s0_aw_prot(aw_prot[0]), .s0_aw_valid(aw_valid[0]), .s0_aw_ready(s_aw_ready[0]),
        .s0_w_data(w_data[0]), .s0_w_strb(w_strb[0]), .s0_w_valid(w_valid[0]), .s0_w_ready(s_w_ready[0]),
        .s0_b_resp(s_b_resp[0]), .s0_b_valid(s_b_valid[0]), .s0_b_ready(b_ready[0]),
        .s0_ar_addr(ar_addr[0]), .s0_ar_prot(ar_prot[0]), .s0_ar_valid(ar_valid[0]), .s0_ar_ready(s_ar_ready[0]),
        .s0_r_data(s_r_data[0]), .s0_r_resp(s_r_resp[0]), .s0_r_valid(s_r_valid[0]), .s0_r_ready(r_ready[0]),
        .s1_aw_addr(aw_addr[1]), .s1_aw_prot(aw_prot[1]), .s1_aw_valid(aw_valid[1]), .s1_aw_ready(s_aw_ready[1]),
        .s1_w_data(w_data[1]), .s1_w_strb(w_strb[1]), .s1_w_valid(w_valid[1]), .s1_w_ready(s_w_ready[1]),
        .s1_b_resp(s_b_resp[1]), .s1_b_valid(s_b_valid[1]), .s1_b_ready(b_ready[1]),
        .s1_ar_addr(ar_addr[1]), .s1_ar_prot(ar_prot[1]), .s1_ar_valid(ar_valid[1]), .s1_ar_ready(s_ar_ready[1]),
        .s1_r_data(s_r_data[1]), .s1_r_resp(s_r_resp[1]), .s1_r_valid(s_r_valid[1]), .s1_r_ready(r_ready[1]),
        .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
        .m_b_resp(mb_resp), .m_b_valid(mb_valid), .m_b_ready(m_b_ready),
        .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_data(mr_data), .m_r_resp(mr_resp), .m_r_valid(mr_valid), .m_r_ready(m_r_ready)
    );

    // ------------------------------------------------------------------
    // Behavioural memory: 16 words, SLVERR when address bit 6 is set,
    // B response optionally delayed by b_stall cycles.
    // ------------------------------------------------------------------
    logic [31:0] mem [16];
    logic        aw_got, w_got;
    logic [31:0] aw_a, w_d, last_ar_addr, last_aw_addr;
    logic [2:0]  last_ar_prot, last_aw_prot;
    logic [3:0]  w_s;
    int          b_wait;
    int          b_stall;

    assign m_ar_ready = ~mr_valid;
    assign m_aw_ready = ~aw_got;
    assign m_w_ready  = ~w_got;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
            mem[4]   <= 32'h1234_5678;
            mr_valid <= 1'b0;
            mr_data  <= '0;
            mr_resp  <= '0;
            mb_valid <= 1'b0;
            mb_resp  <= '0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            b_wait   <= 0;
        end else begin
            if (m_ar_valid && m_ar_ready) begin
                mr_valid     <= 1'b1;
                mr_data      <= mem[m_ar_addr[5:2]];
                mr_resp      <= m_ar_addr[6] ? 2'b10 : 2'b00;
                last_ar_addr <= m_ar_addr;
                last_ar_prot <= m_ar_prot;
            end else if (mr_valid && m_r_ready) begin
                mr_valid <= 1'b0;
            end
            if (m_aw_valid && m_aw_ready) begin
                aw_got       <= 1'b1;
                aw_a         <= m_aw_addr;
                last_aw_addr <= m_aw_addr;
                last_aw_prot <= m_aw_prot;
            end
            if (m_w_valid && m_w_ready) begin
                w_got <= 1'b1;
                w_d   <= m_w_data;
                w_s   <= m_w_strb;
            end
            if (aw_got && w_got && !mb_valid) begin
                if (b_wait >= b_stall) begin
                    mb_valid <= 1'b1;
                    mb_resp  <= aw_a[6] ? 2'b10 : 2'b00;
                    b_wait   <= 0;
                    for (int i = 0; i < 4; i++)
                        if (w_s[i]) mem[aw_a[5:2]][i*8 +: 8] <= w_d[i*8 +: 8];
                end else begin
                    b_wait <= b_wait + 1;
                end
            end
            if (mb_valid && m_b_ready) begin
                mb_valid <= 1'b0;
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: transaction start order and per-port handshake timing
    // ------------------------------------------------------------------
    int cyc;
    int ev_n;
    int ev_port [64];
    int ev_wr   [64];
    int ar_hs_cyc [2];
    int b_hs_cyc  [2];
    int b_hs_cnt  [2];
    int b_vcyc    [2];
    int act_cnt   [2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            ev_n <= 0;
        end else if (ev_n < 64) begin
            if (ar_valid[0] && s_ar_ready[0]) begin
                ev_port[ev_n] <= 0; ev_wr[ev_n] <= 0; ev_n <= ev_n + 1;
            end else if (ar_valid[1] && s_ar_ready[1]) begin
                ev_port[ev_n] <= 1; ev_wr[ev_n] <= 0; ev_n <= ev_n + 1;
            end else if (aw_valid[0] && s_aw_ready[0]) begin
                ev_port[ev_n] <= 0; ev_wr[ev_n] <= 1; ev_n <= ev_n + 1;
            end else if (aw_valid[1] && s_aw_ready[1]) begin
                ev_port[ev_n] <= 1; ev_wr[ev_n] <= 1; ev_n <= ev_n + 1;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (ar_valid[p] && s_ar_ready[p]) ar_hs_cyc[p] <= cyc;
            if (s_b_valid[p] && b_ready[p]) begin
                b_hs_cyc[p] <= cyc;
                b_hs_cnt[p] <= b_hs_cnt[p] + 1;
            end
            if (s_b_valid[p]) b_vcyc[p] <= b_vcyc[p] + 1;
            if (s_aw_ready[p] | s_w_ready[p] | s_b_valid[p] | s_ar_ready[p] | s_r_valid[p])
                act_cnt[p] <= act_cnt[p] + 1;
        end
    end

    logic any_out;
    assign any_out = |{s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid,
                       s_b_resp, s_r_resp, s_r_data,
                       m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready,
                       m_aw_addr, m_w_data, m_w_strb, m_ar_addr, m_aw_prot, m_ar_prot};

    // ------------------------------------------------------------------
    // Checking and requester tasks
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic axi_read(input int p, input logic [31:0] addr,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        ar_addr[p] = addr; ar_prot[p] = 3'b010; ar_valid[p] = 1'b1; r_ready[p] = 1'b1;
        while (!s_ar_ready[p] && n < c_lim) begin @(negedge clk); n++; end
        @(negedge clk); n++;
        ar_valid[p] = 1'b0; ar_addr[p] = '0;
        while (!s_r_valid[p] && n < c_lim) begin @(negedge clk); n++; end
        data = s_r_data[p];
        resp = s_r_resp[p];
        lat  = n;
        @(negedge clk);
        r_ready[p] = 1'b0;
        chk($sformatf("rd%0d_in_time", p), 64'(n < c_lim), 64'd1);
    endtask

    task automatic axi_write(input int p, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
        int   n;
        logic fa, fw;
        n = 0;
        @(negedge clk);
        w_data[p] = data; w_strb[p] = strb; w_valid[p] = 1'b1; b_ready[p] = 1'b1;
        repeat (w_lead) @(negedge clk);
        aw_addr[p] = addr; aw_prot[p] = 3'b001; aw_valid[p] = 1'b1;
        while ((aw_valid[p] || w_valid[p]) && n < c_lim) begin
            fa = aw_valid[p] & s_aw_ready[p];
            fw = w_valid[p] & s_w_ready[p];
            @(negedge clk); n++;
            if (fa) aw_valid[p] = 1'b0;
            if (fw) w_valid[p] = 1'b0;
        end
        while (!s_b_valid[p] && n < c_lim) begin @(negedge clk); n++; end
        resp = s_b_resp[p];
        @(negedge clk);
        b_ready[p] = 1'b0;
        chk($sformatf("wr%0d_in_time", p), 64'(n < c_lim), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0, d1;
        logic [1:0]  rr0, rr1, br;
        int          l0, l1, e0, a0, b0, v0, ok;

        cyc = 0;
        for (int p = 0; p < 2; p++) begin
            ar_hs_cyc[p] = 0; b_hs_cyc[p] = 0; b_hs_cnt[p] = 0; b_vcyc[p] = 0; act_cnt[p] = 0;
        end
        rst = 1'b1; b_stall = 0;
        aw_addr = '0; w_data = '0; ar_addr = '0; aw_prot = '0; ar_prot = '0; w_strb = '0;
        aw_valid = '0; w_valid = '0; b_ready = '0; ar_valid = '0; r_ready = '0;
        repeat (3) @(negedge clk);
        chk("reset_quiet", 64'(any_out), 64'd0);
        rst = 1'b0;

        // Single s0 read, other port must stay silent
        a0 = act_cnt[1];
        axi_read(0, 32'h0000_0010, d0, rr0, l0);
        chk("s0_rd_data", 64'(d0), 64'h1234_5678);
        chk("s0_rd_resp", 64'(rr0), 64'd0);
        chk("s0_rd_latency_le4", 64'(l0 <= 4), 64'd1);
        chk("s1_silent", 64'(act_cnt[1] - a0), 64'd0);
        chk("m_ar_addr_pass", 64'(last_ar_addr), 64'h10);
        chk("m_ar_prot_pass", 64'(last_ar_prot), 64'h2);

        // Read on s0 and write on s1 in the same cycle right after reset
        do_reset();
        e0 = ev_n;
        fork
            axi_read(0, 32'h0000_0004, d0, rr0, l0);
            axi_write(1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 0, br);
        join
        chk("tie_first_port", 64'(ev_port[e0]), 64'd0);
        chk("tie_first_is_read", 64'(ev_wr[e0]), 64'd0);
        chk("tie_second_port", 64'(ev_port[e0+1]), 64'd1);
        chk("tie_second_is_write", 64'(ev_wr[e0+1]), 64'd1);
        chk("tie_rd_data", 64'(d0), 64'h1000_0001);
        chk("s1_b_resp", 64'(br), 64'd0);
        chk("m_aw_addr_pass", 64'(last_aw_addr), 64'h20);
        chk("m_aw_prot_pass", 64'(last_aw_prot), 64'h1);
        axi_read(0, 32'h0000_0020, d0, rr0, l0);
        chk("readback_0x20", 64'(d0), 64'hDEAD_BEEF);

        // s1 write and read together: write wins, read waits for B
        fork
            axi_write(1, 32'h0000_0024, 32'hCAFE_0001, 4'h3, 0, br);
            axi_read(1, 32'h0000_0024, d1, rr1, l1);
        join
        chk("wr_before_rd", 64'(b_hs_cyc[1] < ar_hs_cyc[1]), 64'd1);
        chk("strb_merge_data", 64'(d1), 64'h1000_0001);

        // Both ports reading continuously: strict alternation, s0 first
        e0 = ev_n;
        fork
            for (int i = 0; i < 4; i++) axi_read(0, 32'(i * 4), d0, rr0, l0);
            for (int i = 0; i < 4; i++) axi_read(1, 32'(32 + i * 4), d1, rr1, l1);
        join
        ok = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("alt_grant_%0d", i), 64'(ev_port[e0+i]), 64'(i % 2));
            ok += ev_port[e0+i];
        end
        chk("alt_s1_count", 64'(ok), 64'd4);
        chk("alt_last_s1_data", 64'(d1), 64'h1000_000B);

        // W ahead of AW, slow B, s0 read arriving meanwhile
        b_stall = 3;
        b0 = b_hs_cnt[1];
        v0 = b_vcyc[1];
        fork
            axi_write(1, 32'h0000_0028, 32'h55AA_55AA, 4'hF, 2, br);
            begin
                repeat (3) @(negedge clk);
                axi_read(0, 32'h0000_0028, d0, rr0, l0);
            end
        join
        b_stall = 0;
        chk("slow_b_hs_once", 64'(b_hs_cnt[1] - b0), 64'd1);
        chk("slow_b_valid_cycles", 64'(b_vcyc[1] - v0), 64'd1);
        chk("no_regrant_before_b", 64'(ar_hs_cyc[0] > b_hs_cyc[1]), 64'd1);
        chk("slow_wr_readback", 64'(d0), 64'h55AA_55AA);

        // Error response passes through unmodified
        axi_read(1, 32'h0000_0044, d1, rr1, l1);
        chk("slverr_pass", 64'(rr1), 64'd2);

        // Reset in the middle of a read with R pending
        axi_read(0, 32'h0000_0010, d0, rr0, l0);   // last grant now s0
        @(negedge clk);
        ar_addr[0] = 32'h14; ar_prot[0] = 3'b010; ar_valid[0] = 1'b1; r_ready[0] = 1'b0;
        l0 = 0;
        while (!s_r_valid[0] && l0 < c_lim) begin
            @(negedge clk); l0++;
            if (s_ar_ready[0] == 1'b0 && l0 > 1) ar_valid[0] = 1'b0;
        end
        chk("abort_r_pending", 64'(s_r_valid[0]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_quiet", 64'(any_out), 64'd0);
        ar_valid[0] = 1'b0;
        rst = 1'b0;
        e0 = ev_n;
        fork
            axi_read(0, 32'h0000_0008, d0, rr0, l0);
            axi_read(1, 32'h0000_000C, d1, rr1, l1);
        join
        chk("post_reset_tie_s0", 64'(ev_port[e0]), 64'd0);
        chk("post_reset_s1_data", 64'(d1), 64'h1000_0003);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_z_axil_arbiter
`default_nettype wire
